// File: rtl/packet_ring_buffer_if.sv
// packet_ring_buffer_if: receive-side frame input and packet stream output of the packet buffer
interface packet_ring_buffer_if #(
  parameter int DW = 8,
  parameter int LW = 11
);
  logic          idv;
  logic [DW-1:0] irx_d;
  logic          i_error;
  logic          i_crc_ok;
  logic [DW-1:0] o_data;
  logic          o_valid;
  logic          o_last;
  logic          i_ready;
  logic [LW-1:0] o_len;
  modport master (
    output idv, irx_d, i_error, i_crc_ok, i_ready,
    input  o_data, o_valid, o_last, o_len
  );
  modport slave (
    input  idv, irx_d, i_error, i_crc_ok, i_ready,
    output o_data, o_valid, o_last, o_len
  );
endinterface

// File: rtl/packet_ring_buffer.sv
// packet_ring_buffer: store-and-forward frame buffer with commit/rollback and a packet length FIFO
module packet_ring_buffer #(
  parameter int pDATA_WIDTH        = 8,
  parameter int pMIN_PACKET_LENGHT = 64,
  parameter int pMAX_PACKET_LENGHT = 1536,
  parameter int pDEPTH_RAM         = 4096,
  parameter int pFIFO_DEPTH        = 64,
  parameter int pADDR_WIDTH        = $clog2(pDEPTH_RAM),
  parameter int pLEN_WIDTH         = $clog2(pMAX_PACKET_LENGHT + 1),
  parameter int pCNT_WIDTH         = $clog2(pFIFO_DEPTH + 1)
) (
  input  logic                     iclk,
  input  logic                     i_rst,
  packet_ring_buffer_if.slave      bus,
  output logic [pCNT_WIDTH-1:0]    o_pkt_count,
  output logic [15:0]              o_drop_count
);
  localparam int AW = pADDR_WIDTH;
  localparam int LW = pLEN_WIDTH;
  localparam int PW = pCNT_WIDTH;
  localparam int FW = $clog2(pFIFO_DEPTH);
  localparam logic [2:0] WS_SKIP  = 3'd0;
  localparam logic [2:0] WS_IDLE  = 3'd1;
  localparam logic [2:0] WS_WRITE = 3'd2;
  localparam logic [2:0] WS_CHECK = 3'd3;
  localparam logic [2:0] WS_DROP  = 3'd4;
  localparam logic [0:0] RS_IDLE   = 1'b0;
  localparam logic [0:0] RS_STREAM = 1'b1;
  localparam logic [AW:0]   PTR_ONE   = (AW + 1)'(1);
  localparam logic [AW:0]   RAM_FULL  = (AW + 1)'(pDEPTH_RAM);
  localparam logic [LW-1:0] LEN_ONE   = LW'(1);
  localparam logic [LW-1:0] MIN_LEN   = LW'(pMIN_PACKET_LENGHT);
  localparam logic [LW-1:0] MAX_LEN   = LW'(pMAX_PACKET_LENGHT);
  localparam logic [PW-1:0] FIFO_FULL = PW'(pFIFO_DEPTH);
  localparam logic [FW-1:0] FIFO_LAST = FW'(pFIFO_DEPTH - 1);

  logic [pDATA_WIDTH-1:0] mem [pDEPTH_RAM];
  logic [LW-1:0]          len_mem [pFIFO_DEPTH];
  logic [2:0]             ws_q, ws_d;
  logic [0:0]             rs_q, rs_d;
  logic [AW:0]            wr_ptr_q, wr_ptr_d, commit_q, commit_d, rd_ptr_q, rd_ptr_d, base;
  logic [LW-1:0]          len_q, len_d, rem_q, rem_d, olen_q, olen_d;
  logic                   crc_q, crc_d;
  logic [15:0]            drop_q, drop_d;
  logic [16:0]            drop_sum;
  logic [1:0]             drops;
  logic [FW-1:0]          fwr_q, fwr_d, frd_q, frd_d;
  logic [PW-1:0]          fcnt_q, fcnt_d, pkt_q, pkt_d;
  logic [pDATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [AW-1:0]          waddr;
  logic                   we, push, pop, good, xfer, fifo_full;

  // Write side: frames land past commit_q and are either committed or rolled back in one step
  always_comb begin
    good      = crc_q && len_q >= MIN_LEN && len_q <= MAX_LEN;
    push      = ws_q == WS_CHECK && good;
    base      = push ? wr_ptr_q : commit_q;
    fifo_full = fcnt_q + PW'(push) >= FIFO_FULL;
    ws_d      = ws_q;
    wr_ptr_d  = wr_ptr_q;
    commit_d  = base;
    len_d     = len_q;
    crc_d     = crc_q;
    drops     = 2'd0;
    we        = 1'b0;
    waddr     = wr_ptr_q[AW-1:0];
    case (ws_q)
      WS_SKIP: ws_d = bus.idv ? WS_SKIP : WS_IDLE;
      WS_IDLE, WS_CHECK: begin
        drops    = {1'b0, ws_q == WS_CHECK && !good};
        wr_ptr_d = base;
        ws_d     = WS_IDLE;
        if (bus.idv) begin
          if (fifo_full || bus.i_error || base - rd_ptr_q == RAM_FULL) begin
            ws_d  = WS_DROP;
            drops = drops + 2'd1;
          end else begin
            we       = 1'b1;
            waddr    = base[AW-1:0];
            wr_ptr_d = base + PTR_ONE;
            len_d    = LEN_ONE;
            ws_d     = WS_WRITE;
          end
        end
      end
      WS_WRITE: begin
        if (bus.idv) begin
          if (bus.i_error || len_q == MAX_LEN || wr_ptr_q - rd_ptr_q == RAM_FULL) begin
            ws_d     = WS_DROP;
            wr_ptr_d = commit_q;
            drops    = 2'd1;
          end else begin
            we       = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            len_d    = len_q + LEN_ONE;
          end
        end else begin
          crc_d = bus.i_crc_ok;
          ws_d  = WS_CHECK;
        end
      end
      WS_DROP: begin
        wr_ptr_d = commit_q;
        ws_d     = bus.idv ? WS_DROP : WS_IDLE;
      end
      default: ws_d = WS_SKIP;
    endcase
    drop_sum = {1'b0, drop_q} + 17'(drops);
    drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  // Read side: pop a length, then stream with a registered RAM read one word ahead on each transfer
  always_comb begin
    xfer     = rs_q == RS_STREAM && bus.i_ready;
    pop      = rs_q == RS_IDLE && fcnt_q != '0;
    rs_d     = rs_q;
    rd_ptr_d = rd_ptr_q;
    rem_d    = rem_q;
    olen_d   = olen_q;
    if (pop) begin
      olen_d = len_mem[frd_q];
      rem_d  = len_mem[frd_q];
      rs_d   = RS_STREAM;
    end
    if (xfer) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
      rem_d    = rem_q - LEN_ONE;
      rs_d     = rem_q == LEN_ONE ? RS_IDLE : RS_STREAM;
    end
    rdata_d = rs_d == RS_STREAM ? mem[rd_ptr_d[AW-1:0]] : rdata_q;
    fwr_d   = push ? (fwr_q == FIFO_LAST ? '0 : fwr_q + FW'(1)) : fwr_q;
    frd_d   = pop ? (frd_q == FIFO_LAST ? '0 : frd_q + FW'(1)) : frd_q;
    fcnt_d  = fcnt_q + PW'(push) - PW'(pop);
    pkt_d   = pkt_q + PW'(push) - PW'(xfer && rem_q == LEN_ONE);
  end

  // Data RAM and length FIFO storage; no reset needed since pointers gate visibility
  always_ff @(posedge iclk) begin
    if (we) mem[waddr] <= bus.irx_d;
    if (push) len_mem[fwr_q] <= len_q;
  end

  // State, pointers and counters
  always_ff @(posedge iclk or posedge i_rst) begin
    if (i_rst) begin
      ws_q     <= WS_SKIP;
      rs_q     <= RS_IDLE;
      wr_ptr_q <= '0;
      commit_q <= '0;
      rd_ptr_q <= '0;
      len_q    <= '0;
      rem_q    <= '0;
      olen_q   <= '0;
      crc_q    <= 1'b0;
      drop_q   <= '0;
      fwr_q    <= '0;
      frd_q    <= '0;
      fcnt_q   <= '0;
      pkt_q    <= '0;
      rdata_q  <= '0;
    end else begin
      ws_q     <= ws_d;
      rs_q     <= rs_d;
      wr_ptr_q <= wr_ptr_d;
      commit_q <= commit_d;
      rd_ptr_q <= rd_ptr_d;
      len_q    <= len_d;
      rem_q    <= rem_d;
      olen_q   <= olen_d;
      crc_q    <= crc_d;
      drop_q   <= drop_d;
      fwr_q    <= fwr_d;
      frd_q    <= frd_d;
      fcnt_q   <= fcnt_d;
      pkt_q    <= pkt_d;
      rdata_q  <= rdata_d;
    end
  end

  assign bus.o_data   = rdata_q;
  assign bus.o_valid  = rs_q;
  assign bus.o_last   = rs_q == RS_STREAM && rem_q == LEN_ONE;
  assign bus.o_len    = olen_q;
  assign o_pkt_count  = pkt_q;
  assign o_drop_count = drop_q;
endmodule

// File: tb/tb_packet_ring_buffer.sv
// tb_packet_ring_buffer: directed scenarios against a byte scoreboard for the packet buffer
module tb_packet_ring_buffer;
  localparam int DW = 8;
  localparam int LW = 11;
  localparam int PW = 7;
  logic iclk = 1'b0;
  logic i_rst = 1'b1;
  logic [PW-1:0] pkt_count;
  logic [15:0] drop_count;
  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];
  int exp_len[$];
  int cur_len = 0;
  int idx = 0;
  int rx_words = 0;
  bit valid_seen = 0;
  bit prev_stall = 0;
  logic [7:0] prev_data, exp_byte;
  logic prev_last;
  logic [LW-1:0] prev_len;

  packet_ring_buffer_if #(.DW(DW), .LW(LW)) bus();
  packet_ring_buffer #(.pDEPTH_RAM(2048)) dut (
    .iclk(iclk), .i_rst(i_rst), .bus(bus), .o_pkt_count(pkt_count), .o_drop_count(drop_count)
  );

  always #5 iclk = ~iclk;

  // Scoreboard: every transfer checked for data, length sideband and last marking; stalls must hold
  always @(negedge iclk) begin
    if (i_rst) prev_stall = 0;
    else begin
      if (bus.o_valid) valid_seen = 1;
      if (prev_stall) begin
        total++;
        if (bus.o_valid !== 1'b1 || bus.o_data !== prev_data || bus.o_last !== prev_last || bus.o_len !== prev_len) begin
          bad++;
          $display("FAIL stall_hold valid=%b data=%h last=%b len=%0d required valid=1 data=%h last=%b len=%0d",
                   bus.o_valid, bus.o_data, bus.o_last, bus.o_len, prev_data, prev_last, prev_len);
        end
      end
      if (bus.o_valid && bus.i_ready) begin
        if (idx == 0) cur_len = exp_len.size() != 0 ? exp_len.pop_front() : -1;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_word data=%h required no transfer", bus.o_data);
        end else begin
          exp_byte = exp_q.pop_front();
          if (bus.o_data !== exp_byte || bus.o_len !== LW'(cur_len) || bus.o_last !== (idx == cur_len - 1)) begin
            bad++;
            $display("FAIL xfer word %0d data=%h len=%0d last=%b required data=%h len=%0d last=%b",
                     idx, bus.o_data, bus.o_len, bus.o_last, exp_byte, cur_len, idx == cur_len - 1);
          end
        end
        rx_words++;
        idx = (idx >= cur_len - 1) ? 0 : idx + 1;
      end
      prev_stall = bus.o_valid && !bus.i_ready;
      prev_data = bus.o_data;
      prev_last = bus.o_last;
      prev_len = bus.o_len;
    end
  end

  task automatic tick();
    @(posedge iclk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
    bus.i_crc_ok = 1'b0;
  endtask

  task automatic send(input int n, input int err_at, input bit crc, input logic [7:0] seed, input bit keep);
    if (keep) begin
      for (int i = 0; i < n; i++) exp_q.push_back(seed + 8'(i));
      exp_len.push_back(n);
    end
    for (int i = 0; i < n; i++) begin
      tick();
      bus.idv = 1'b1;
      bus.irx_d = seed + 8'(i);
      bus.i_error = (i == err_at);
    end
    tick();
    bus.idv = 1'b0;
    bus.i_error = 1'b0;
    bus.i_crc_ok = crc;
  endtask

  task automatic drain(input int budget);
    int c = 0;
    while ((exp_q.size() != 0 || pkt_count != 0) && c < budget) begin
      @(negedge iclk);
      c++;
    end
    total++;
    if (exp_q.size() != 0 || pkt_count !== 0) begin
      bad++;
      $display("FAIL drain words_left=%0d pkt_count=%0d required 0 and 0", exp_q.size(), pkt_count);
    end
    idle(3);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge iclk);
    total++;
    if (bus.o_valid !== 1'b0 || bus.o_last !== 1'b0 || bus.o_data !== 8'h00) begin
      bad++;
      $display("FAIL reset_stream valid=%b last=%b data=%h required 0 0 00", bus.o_valid, bus.o_last, bus.o_data);
    end
    total++;
    if (bus.o_len !== '0 || pkt_count !== '0 || drop_count !== 16'd0) begin
      bad++;
      $display("FAIL reset_counts len=%0d pkt=%0d drop=%0d required 0 0 0", bus.o_len, pkt_count, drop_count);
    end
    tick();
    i_rst = 1'b0;
    idle(2);
  endtask

  task automatic test_two_good();
    int w0 = rx_words;
    bus.i_ready = 1'b0;
    send(64, -1, 1'b1, 8'h10, 1'b1);
    send(64, -1, 1'b1, 8'h10, 1'b1);
    idle(6);
    @(negedge iclk);
    total++;
    if (pkt_count !== 7'd2) begin
      bad++;
      $display("FAIL two_good_pkt_count got=%0d required 2", pkt_count);
    end
    total++;
    if (bus.o_valid !== 1'b1 || bus.o_len !== 11'd64 || bus.o_data !== 8'h10 || bus.o_last !== 1'b0) begin
      bad++;
      $display("FAIL two_good_head valid=%b len=%0d data=%h last=%b required 1 64 10 0",
               bus.o_valid, bus.o_len, bus.o_data, bus.o_last);
    end
    tick();
    bus.i_ready = 1'b1;
    drain(1000);
    total++;
    if (rx_words - w0 != 128) begin
      bad++;
      $display("FAIL two_good_words got=%0d required 128", rx_words - w0);
    end
  endtask

  task automatic test_error_rollback();
    int w0 = rx_words;
    send(100, 49, 1'b1, 8'h40, 1'b0);
    send(70, -1, 1'b1, 8'h80, 1'b1);
    idle(2);
    drain(1000);
    total++;
    if (drop_count !== 16'd1 || rx_words - w0 != 70) begin
      bad++;
      $display("FAIL error_rollback drop=%0d words=%0d required 1 70", drop_count, rx_words - w0);
    end
  endtask

  task automatic test_length_limits();
    int w0;
    valid_seen = 0;
    send(63, -1, 1'b1, 8'h01, 1'b0);
    send(1537, -1, 1'b1, 8'h02, 1'b0);
    idle(6);
    @(negedge iclk);
    total++;
    if (valid_seen !== 1'b0 || drop_count !== 16'd3 || pkt_count !== 7'd0) begin
      bad++;
      $display("FAIL short_long valid_seen=%b drop=%0d pkt=%0d required 0 3 0", valid_seen, drop_count, pkt_count);
    end
    w0 = rx_words;
    send(1536, -1, 1'b1, 8'h03, 1'b1);
    send(64, -1, 1'b0, 8'h04, 1'b0);
    idle(2);
    drain(3000);
    total++;
    if (drop_count !== 16'd4 || rx_words - w0 != 1536) begin
      bad++;
      $display("FAIL max_len_and_crc drop=%0d words=%0d required 4 1536", drop_count, rx_words - w0);
    end
  endtask

  task automatic test_ram_full();
    int w0 = rx_words;
    bus.i_ready = 1'b0;
    send(1000, -1, 1'b1, 8'h11, 1'b1);
    send(1000, -1, 1'b1, 8'h22, 1'b1);
    send(100, -1, 1'b1, 8'h33, 1'b0);
    idle(6);
    @(negedge iclk);
    total++;
    if (drop_count !== 16'd5 || pkt_count !== 7'd2) begin
      bad++;
      $display("FAIL ram_full drop=%0d pkt=%0d required 5 2", drop_count, pkt_count);
    end
    tick();
    bus.i_ready = 1'b1;
    drain(3000);
    total++;
    if (rx_words - w0 != 2000) begin
      bad++;
      $display("FAIL ram_full_words got=%0d required 2000", rx_words - w0);
    end
  endtask

  task automatic test_back_to_back();
    int w0 = rx_words;
    int sum = 0;
    bit done = 0;
    fork
      begin
        for (int f = 0; f < 20; f++) begin
          int n = $urandom_range(64, 160);
          sum += n;
          send(n, -1, 1'b1, 8'($urandom), 1'b1);
          if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 20));
        end
        done = 1;
      end
      begin
        while (!done) begin
          tick();
          bus.i_ready = $urandom_range(0, 3) != 0;
        end
      end
    join
    bus.i_ready = 1'b1;
    drain(10000);
    total++;
    if (drop_count !== 16'd5 || rx_words - w0 != sum) begin
      bad++;
      $display("FAIL random_ready drop=%0d words=%0d required 5 %0d", drop_count, rx_words - w0, sum);
    end
  endtask

  task automatic test_reset_mid();
    int w0 = 0;
    bus.i_ready = 1'b1;
    send(80, -1, 1'b1, 8'h55, 1'b1);
    for (int i = 0; i < 100; i++) begin
      tick();
      bus.idv = 1'b1;
      bus.irx_d = 8'(i);
      if (i == 30) i_rst = 1'b1;
      if (i == 32) i_rst = 1'b0;
      if (i == 31) begin
        @(negedge iclk);
        total++;
        if (bus.o_valid !== 1'b0 || bus.o_data !== 8'h00 || bus.o_last !== 1'b0 || bus.o_len !== '0 ||
            pkt_count !== '0 || drop_count !== 16'd0) begin
          bad++;
          $display("FAIL mid_reset valid=%b data=%h last=%b len=%0d pkt=%0d drop=%0d required all 0",
                   bus.o_valid, bus.o_data, bus.o_last, bus.o_len, pkt_count, drop_count);
        end
        exp_q.delete();
        exp_len.delete();
        idx = 0;
        w0 = rx_words;
      end
    end
    tick();
    bus.idv = 1'b0;
    send(64, -1, 1'b1, 8'h66, 1'b1);
    idle(2);
    drain(1000);
    total++;
    if (rx_words - w0 != 64 || drop_count !== 16'd0) begin
      bad++;
      $display("FAIL after_reset words=%0d drop=%0d required 64 0", rx_words - w0, drop_count);
    end
  endtask

  initial begin
    bus.idv = 1'b0;
    bus.irx_d = '0;
    bus.i_error = 1'b0;
    bus.i_crc_ok = 1'b0;
    bus.i_ready = 1'b1;
    test_reset();
    test_two_good();
    test_error_rollback();
    test_length_limits();
    test_ram_full();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
